cu_sequencer: RTL

Parametrised multi-cycle control sequencer for the RV32I core. It generalises the fixed four-state fetch/load-IR/execute/write-back controller with:
- ready-handshaked instruction and data bus waits;
- a dedicated memory stage;
- an optional write-back skip for instructions without a destination;
- bus-timeout and illegal-opcode traps;
- an optional retired-instruction counter.

It sits between the bus interfaces and the datapath. It drives the stage strobes consumed by the PC, IR, register file and data bus. Datapath/ALU field decode stays outside this block.

---
 rtl/cu_sequencer_if.sv | 51 +++++
 rtl/cu_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cu_sequencer_if.sv
// cu_sequencer_if: handshake and stage-strobe bundle between cu_sequencer and the core.
// The instret member exists only when CU_INSTRET_EN is defined.
interface cu_sequencer_if #(
   parameter int unsigned INSTRET_WIDTH = 32
) ();

   logic [6:0] opcode;
   logic       stall;
   logic       ibus_ready;
   logic       dbus_ready;
   logic       trap_ack;

   logic       fetch_next_instruction;
   logic       load_ir;
   logic       en_pc_counter;
   logic       mem_stage;
   logic       dbus_re;
   logic       dbus_we;
   logic       write_back_stage;
   logic       retire;
   logic       trap;
   logic       illegal_instr;
   logic       bus_error;
`ifdef CU_INSTRET_EN
   logic [INSTRET_WIDTH-1:0] instret;
`endif

   if (INSTRET_WIDTH == 0) begin : g_bad_instret_width
      $error("INSTRET_WIDTH must be at least 1");
   end

   // master: the sequencer itself; slave: the datapath/bus side.
   modport master (
      input  opcode, stall, ibus_ready, dbus_ready, trap_ack,
      output fetch_next_instruction, load_ir, en_pc_counter, mem_stage, dbus_re, dbus_we,
      output write_back_stage, retire, trap, illegal_instr, bus_error
`ifdef CU_INSTRET_EN
      , output instret
`endif
   );

   modport slave (
      output opcode, stall, ibus_ready, dbus_ready, trap_ack,
      input  fetch_next_instruction, load_ir, en_pc_counter, mem_stage, dbus_re, dbus_we,
      input  write_back_stage, retire, trap, illegal_instr, bus_error
`ifdef CU_INSTRET_EN
      , input instret
`endif
   );

endinterface

// File: rtl/cu_sequencer.sv
// cu_sequencer: multi-cycle RV32I control FSM with bus-ready waits, timeout and illegal traps.
// Define CU_INSTRET_EN to add the retired-instruction counter (bus.instret).
module cu_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES  = 16,
   parameter bit          SKIP_WB_NO_DEST = 1'b1,
   parameter int unsigned INSTRET_WIDTH   = 32
) (
   input logic            clk,
   input logic            rst_n,
   cu_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      StNull, StFetch, StLoadIr, StExec, StMem, StWb, StTrap
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   // The counter only needs to hold TIMEOUT_CYCLES-1; the limit cycle traps instead.
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              is_store_q, is_store_d;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;
   logic              retire_d;
   logic              timeout_hit;

   logic fetch_q, load_ir_q, exec_q, mem_q, re_q, we_q, wb_q, retire_q, trap_q;

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_store_d = is_store_q;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      if (!bus.stall) begin
         unique case (state_q)
            StNull:   state_d = StFetch;
            StFetch: begin
               if (bus.ibus_ready) begin
                  state_d = StLoadIr;
               end else if (timeout_hit) begin
                  state_d   = StTrap;
                  bus_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StLoadIr: state_d = StExec;
            StExec: begin
               is_store_d = (bus.opcode == OpStore);
               case (bus.opcode)
                  OpLoad, OpStore:                        state_d = StMem;
                  OpReg, OpImm, OpJal, OpJalr, OpLui, OpAuipc: state_d = StWb;
                  OpBranch: state_d = SKIP_WB_NO_DEST ? StFetch : StWb;
                  default: begin
                     state_d   = StTrap;
                     illegal_d = 1'b1;
                  end
               endcase
            end
            StMem: begin
               if (bus.dbus_ready) begin
                  state_d = (is_store_q && SKIP_WB_NO_DEST) ? StFetch : StWb;
               end else if (timeout_hit) begin
                  state_d   = StTrap;
                  bus_err_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StWb:     state_d = StFetch;
            StTrap: begin
               if (bus.trap_ack) begin
                  state_d   = StFetch;
                  illegal_d = 1'b0;
                  bus_err_d = 1'b0;
               end
            end
            default:  state_d = StNull;
         endcase
      end
      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   assign retire_d = (state_d == StFetch) &&
                     ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));

   // Strobes are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StNull;
         cnt_q      <= '0;
         is_store_q <= 1'b0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
         fetch_q    <= 1'b0;
         load_ir_q  <= 1'b0;
         exec_q     <= 1'b0;
         mem_q      <= 1'b0;
         re_q       <= 1'b0;
         we_q       <= 1'b0;
         wb_q       <= 1'b0;
         retire_q   <= 1'b0;
         trap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_store_q <= is_store_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
         fetch_q    <= (state_d == StFetch);
         load_ir_q  <= (state_d == StLoadIr);
         exec_q     <= (state_d == StExec);
         mem_q      <= (state_d == StMem);
         re_q       <= (state_d == StMem) && !is_store_d;
         we_q       <= (state_d == StMem) && is_store_d;
         wb_q       <= (state_d == StWb);
         retire_q   <= retire_d;
         trap_q     <= (state_d == StTrap);
      end
   end

   assign bus.fetch_next_instruction = fetch_q;
   assign bus.load_ir                = load_ir_q;
   assign bus.en_pc_counter          = exec_q;
   assign bus.mem_stage              = mem_q;
   assign bus.dbus_re                = re_q;
   assign bus.dbus_we                = we_q;
   assign bus.write_back_stage       = wb_q;
   assign bus.retire                 = retire_q;
   assign bus.trap                   = trap_q;
   assign bus.illegal_instr          = illegal_q;
   assign bus.bus_error              = bus_err_q;

`ifdef CU_INSTRET_EN
   // Counts on the edge that raises retire, so both become visible together.
   logic [INSTRET_WIDTH-1:0] instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_q <= '0;
      end else if (retire_d) begin
         instret_q <= instret_q + INSTRET_WIDTH'(1);
      end
   end

   assign bus.instret = instret_q;
`else
   if (INSTRET_WIDTH == 0) begin : g_bad_instret_width
      $error("INSTRET_WIDTH must be at least 1");
   end
`endif

endmodule
